wb_cpu_decoder: RTL

WB_CPU_DECODER -- requirements
Module: wb_cpu_decoder

---
 rtl/wb_cpu_decoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wb_cpu_decoder.sv
// Wishbone CPU-side address decoder: routes one CPU access at a time to one of
// three slaves by adr[31:28], with ack timeout and a sticky bus-error record.
module wb_cpu_decoder #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [3:0]  S0_BASE = 4'h0,
    parameter logic [3:0]  S1_BASE = 4'h4,
    parameter logic [3:0]  S2_BASE = 4'h8
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [31:0] wb_cpu_adr,
    input  logic [31:0] wb_cpu_dat,
    input  logic [3:0]  wb_cpu_sel,
    input  logic        wb_cpu_we,
    input  logic        wb_cpu_cyc,
    input  logic        wb_cpu_stb,
    output logic [31:0] wb_cpu_rdt,
    output logic        wb_cpu_ack,
    output logic [31:0] wb_s_adr,
    output logic [31:0] wb_s_dat,
    output logic [3:0]  wb_s_sel,
    output logic        wb_s_we,
    output logic        wb_s0_cyc,
    output logic        wb_s1_cyc,
    output logic        wb_s2_cyc,
    input  logic [31:0] wb_s0_rdt,
    input  logic        wb_s0_ack,
    input  logic [31:0] wb_s1_rdt,
    input  logic        wb_s1_ack,
    input  logic [31:0] wb_s2_rdt,
    input  logic        wb_s2_ack,
    output logic        err,
    output logic [31:0] err_adr,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERRW, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sel_q, sel_d;
    logic [15:0] cnt;
    logic        req, hit_ack, timeout_hit;
    logic [31:0] hit_rdt;

    assign req         = wb_cpu_cyc & wb_cpu_stb;
    assign sel_d       = {wb_cpu_adr[31:28] == S2_BASE,
                          wb_cpu_adr[31:28] == S1_BASE,
                          wb_cpu_adr[31:28] == S0_BASE};
    assign timeout_hit = (cnt == 16'(TIMEOUT - 1));

    // Only the selected slave's response is looked at; others are ignored.
    always_comb begin
        hit_ack = 1'b0;
        hit_rdt = '0;
        if (sel_q[0]) begin
            hit_ack = wb_s0_ack;
            hit_rdt = wb_s0_rdt;
        end else if (sel_q[1]) begin
            hit_ack = wb_s1_ack;
            hit_rdt = wb_s1_rdt;
        end else if (sel_q[2]) begin
            hit_ack = wb_s2_ack;
            hit_rdt = wb_s2_rdt;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // An ack arriving on the timeout cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = (|sel_d) ? ACTIVE : ERRW;
            ACTIVE:  if (hit_ack) state_nxt = DONE;
                     else if (timeout_hit) state_nxt = ERRW;
            ERRW:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wb_s0_cyc  = (state == ACTIVE) & sel_q[0];
        wb_s1_cyc  = (state == ACTIVE) & sel_q[1];
        wb_s2_cyc  = (state == ACTIVE) & sel_q[2];
        wb_cpu_ack = (state == DONE);
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wb_s_adr   <= '0;
            wb_s_dat   <= '0;
            wb_s_sel   <= '0;
            wb_s_we    <= 1'b0;
            sel_q      <= '0;
            cnt        <= '0;
            wb_cpu_rdt <= '0;
            err        <= 1'b0;
            err_adr    <= '0;
        end else begin
            if (state == IDLE && req) begin
                wb_s_adr <= wb_cpu_adr;
                wb_s_dat <= wb_cpu_dat;
                wb_s_sel <= wb_cpu_sel;
                wb_s_we  <= wb_cpu_we;
                sel_q    <= sel_d;
            end
            cnt <= (state == ACTIVE && state_nxt == ACTIVE) ? cnt + 16'd1 : '0;
            if (state == ACTIVE && hit_ack) wb_cpu_rdt <= hit_rdt;
            else if (state == ERRW)         wb_cpu_rdt <= '0;
            // A simultaneous clear lets the new error re-capture its address.
            if (state == ERRW) begin
                err <= 1'b1;
                if (!err || err_clr) err_adr <= wb_s_adr;
            end else if (err_clr) begin
                err     <= 1'b0;
                err_adr <= '0;
            end
        end
    end

endmodule
